branch_pht_scheduler: RTL

- Owns a single-ported pattern history table (PHT) of 2-bit saturating counters.
- Schedules the one table access per cycle between decode-stage prediction lookups and EX-stage feedback updates.
- Feedback is queued in a small FIFO and retired by a read-then-write update sequencer, with a starvation guard.
- Sits between the branch controller (request/feedback sides) and the PHT storage; replaces direct dual-access counter arrays.

---
 rtl/branch_pht_scheduler.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/branch_pht_scheduler.sv
// PHT of 2-bit saturating counters behind one table port shared by decode lookups and a
// queued read-then-write feedback updater. Define BRANCH_PHT_BYPASS_EN to forward queued outcomes into lookups.
module branch_pht_scheduler #(
    parameter int ADDR_WIDTH = 32,
    parameter int IDX_W      = 10,
    parameter int FB_DEPTH   = 4,
    parameter int MAX_WAIT   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_req_valid,
    input  logic [ADDR_WIDTH-1:0]         i_req_pc,
    output logic                          o_req_prediction,
    output logic                          o_req_fallback,
    input  logic                          i_fb_valid,
    input  logic [ADDR_WIDTH-1:0]         i_fb_pc,
    input  logic                          i_fb_outcome,
    output logic                          o_fb_full,
    output logic [$clog2(FB_DEPTH):0]     o_fb_count,
    output logic [15:0]                   o_drop_count
);

    localparam int PTR_W   = $clog2(FB_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam int ENTRIES = 1 << IDX_W;

    // Handshake: i_req_valid is a same-cycle request with no ready; a lookup is served
    // when o_req_fallback is 0. i_fb_valid is accepted unless the FIFO is full and no
    // pop happens that cycle, in which case the entry is dropped and counted.

    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;

    state_t             state;
    state_t             state_next;
    logic [1:0]         pht [ENTRIES];
    logic [IDX_W-1:0]   fb_idx_q [FB_DEPTH];
    logic               fb_out_q [FB_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic               full;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [1:0]         rd_val;
    logic [1:0]         wr_val;
    logic [1:0]         lookup_val;
    logic [15:0]        drop_count;

    logic [IDX_W-1:0]   req_idx;
    logic [IDX_W-1:0]   fb_in_idx;
    logic [IDX_W-1:0]   head_idx;
    logic               head_out;
    logic               need_port;
    logic               upd_grant;
    logic               pop;
    logic               push;
    logic               drop;
    logic               unused_pc_bits;

    function automatic logic [1:0] sat_upd(input logic [1:0] v, input logic taken);
        if (taken) return (v == 2'd3) ? 2'd3 : v + 2'd1;
        return (v == 2'd0) ? 2'd0 : v - 2'd1;
    endfunction

    assign req_idx   = i_req_pc[IDX_W+1:2];
    assign fb_in_idx = i_fb_pc[IDX_W+1:2];
    assign head_idx  = fb_idx_q[rd_ptr];
    assign head_out  = fb_out_q[rd_ptr];
    assign unused_pc_bits = ^{i_req_pc[ADDR_WIDTH-1:IDX_W+2], i_req_pc[1:0],
                              i_fb_pc[ADDR_WIDTH-1:IDX_W+2], i_fb_pc[1:0]};

    // Updater wins when the decoder is silent or it has starved for MAX_WAIT cycles.
    assign need_port  = (state == RD) || (state == WR);
    assign upd_grant  = need_port && (!i_req_valid || (wait_cnt == WAIT_W'(MAX_WAIT)));
    assign pop        = (state == WR) && upd_grant;
    assign push       = i_fb_valid && (!full || pop);
    assign drop       = i_fb_valid && !push;
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);
    assign wr_val     = sat_upd(rd_val, head_out);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (count != '0) state_next = RD;
            RD:   if (upd_grant) state_next = WR;
            WR:   if (upd_grant) state_next = (count_next != '0) ? RD : IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef BRANCH_PHT_BYPASS_EN
    logic [PTR_W-1:0] slot;
    // Fold every pending outcome for this index, oldest first, over the table value.
    always_comb begin
        lookup_val = pht[req_idx];
        slot       = '0;
        for (int k = 0; k < FB_DEPTH; k++) begin
            slot = rd_ptr + PTR_W'(k);
            if ((CNT_W'(k) < count) && (fb_idx_q[slot] == req_idx))
                lookup_val = sat_upd(lookup_val, fb_out_q[slot]);
        end
    end
`else
    always_comb begin
        lookup_val = pht[req_idx];
    end
`endif

    assign o_req_fallback   = i_req_valid && upd_grant;
    assign o_req_prediction = i_req_valid && !upd_grant && lookup_val[1];
    assign o_fb_full        = full;
    assign o_fb_count       = count;
    assign o_drop_count     = drop_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) pht[i] <= 2'b01;
        end else if (pop) begin
            pht[head_idx] <= wr_val;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fb_idx_q[wr_ptr] <= fb_in_idx;
            fb_out_q[wr_ptr] <= i_fb_outcome;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            full       <= 1'b0;
            wait_cnt   <= '0;
            rd_val     <= 2'b01;
            drop_count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            full  <= (count_next == CNT_W'(FB_DEPTH));
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (upd_grant)
                wait_cnt <= '0;
            else if (need_port && (wait_cnt != WAIT_W'(MAX_WAIT)))
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if ((state == RD) && upd_grant) rd_val <= pht[head_idx];
            if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
        end
    end

endmodule
